// File: rtl/mstage_pkg.sv
// Shared constants for the M-stage load/store unit.
// Funct3 memory op codes, FSM state encodings, default context width.
package mstage_pkg;

  localparam int CTX_W_DEFAULT = 352;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RSP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/mstage_lsu_if.sv
// Data bus interface: single-outstanding req/rsp handshake.
// master = LSU side, slave = memory side.
interface mstage_lsu_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mstage_lsu_align.sv
// Byte-lane alignment: strobes, store shift, load extend, misalign.
// LSU_MISALIGN_CHECK_EN enables the misalignment detector.
module lsu_align
  import mstage_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  op,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [31:0] rsh;

  assign rsh      = rdata >> {addr_lo, 3'b000};
  assign wdata_sh = wdata << {addr_lo, 3'b000};

  // Decode size/sign into lane strobes and load extension
  always_comb begin
    wstrb     = 4'b0000;
    rdata_ext = rsh;
    unique case (1'b1)
      op == MEMOP_B: begin
        wstrb     = 4'b0001 << addr_lo;
        rdata_ext = {{24{rsh[7]}}, rsh[7:0]};
      end
      op == MEMOP_H: begin
        wstrb     = 4'b0011 << addr_lo;
        rdata_ext = {{16{rsh[15]}}, rsh[15:0]};
      end
      op == MEMOP_W: begin
        wstrb     = 4'b1111;
        rdata_ext = rsh;
      end
      op == MEMOP_BU: begin
        rdata_ext = {24'h0, rsh[7:0]};
      end
      op == MEMOP_HU: begin
        rdata_ext = {16'h0, rsh[15:0]};
      end
      default: begin
        wstrb     = 4'b0000;
        rdata_ext = rsh;
      end
    endcase
  end

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = (op[1:0] == 2'b01 && addr_lo[0]) ||
                    (op[1:0] == 2'b10 && addr_lo != 2'b00);
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: rtl/mstage_lsu.sv
// M-stage load/store unit: E handshake in, bus access, W handshake out.
// Misalign trap path built only with LSU_MISALIGN_CHECK_EN.
module mstage_lsu
  import mstage_pkg::*;
#(
  parameter int CTX_W = CTX_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [CTX_W-1:0] ctxE,
  input  logic             memenE,
  input  logic             memweE,
  input  logic [2:0]       memopE,
  input  logic [31:0]      addrE,
  input  logic [31:0]      wdataE,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CTX_W-1:0] ctxM,
  output logic [31:0]      mdataM,
  output logic             memerrM,
  output logic             misalignM,
  mstage_lsu_if.master     bus
);

  logic [1:0]       state;
  logic [CTX_W-1:0] ctx_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [2:0]       op_q;
  logic             we_q;
  logic [31:0]      mdata_q;
  logic             err_q;
  logic             mis_q;

  logic             idle;
  logic             in_req;
  logic [1:0]       a_lo;
  logic [2:0]       a_op;
  logic [3:0]       al_wstrb;
  logic [31:0]      al_wdata;
  logic [31:0]      al_rdata;
  logic             al_mis;

  assign idle   = (state == ST_IDLE);
  assign in_req = (state == ST_REQ);

  // In IDLE the aligner looks at the incoming op to flag misalignment;
  // afterwards it works on the latched op for the bus and response.
  assign a_lo = idle ? addrE[1:0] : addr_q[1:0];
  assign a_op = idle ? memopE     : op_q;

  lsu_align u_align (
    .addr_lo   (a_lo),
    .op        (a_op),
    .wdata     (wdata_q),
    .rdata     (bus.rsp_rdata),
    .wstrb     (al_wstrb),
    .wdata_sh  (al_wdata),
    .rdata_ext (al_rdata),
    .misalign  (al_mis)
  );

  // FSM and latched instruction/result fields
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      ctx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= '0;
      we_q    <= 1'b0;
      mdata_q <= '0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (s_valid) begin
            ctx_q   <= ctxE;
            addr_q  <= addrE;
            wdata_q <= wdataE;
            op_q    <= memopE;
            we_q    <= memenE & memweE;
            mdata_q <= '0;
            err_q   <= 1'b0;
            mis_q   <= memenE & al_mis;
            if (!memenE || al_mis)
              state <= ST_DONE;
            else
              state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.req_ready)
            state <= ST_RSP;
        end
        ST_RSP: begin
          if (bus.rsp_valid) begin
            mdata_q <= (we_q || bus.rsp_err) ? 32'h0 : al_rdata;
            err_q   <= bus.rsp_err;
            state   <= ST_DONE;
          end
        end
        default: begin
          if (m_ready)
            state <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_ready   = idle;
  assign m_valid   = (state == ST_DONE);
  assign ctxM      = ctx_q;
  assign mdataM    = mdata_q;
  assign memerrM   = err_q;
  assign misalignM = mis_q;

  // Bus fields are only driven while a request is outstanding
  assign bus.req_valid = in_req;
  assign bus.req_we    = in_req & we_q;
  assign bus.req_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus.req_wdata = (in_req && we_q) ? al_wdata : 32'h0;
  assign bus.req_wstrb = (in_req && we_q) ? al_wstrb : 4'b0000;

endmodule

// File: tb/tb_mstage_lsu.sv
// Directed bench for mstage_lsu: vector table plus stall/reset/misalign
// sequences; define LSU_MISALIGN_CHECK_EN to match the RTL build.
module tb_mstage_lsu;
  import mstage_pkg::*;

  localparam int CW = 352;

  logic          clk;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [CW-1:0] ctxE;
  logic          memenE;
  logic          memweE;
  logic [2:0]    memopE;
  logic [31:0]   addrE;
  logic [31:0]   wdataE;
  logic          m_valid;
  logic          m_ready;
  logic [CW-1:0] ctxM;
  logic [31:0]   mdataM;
  logic          memerrM;
  logic          misalignM;

  mstage_lsu_if bus ();

  mstage_lsu #(.CTX_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .ctxE      (ctxE),
    .memenE    (memenE),
    .memweE    (memweE),
    .memopE    (memopE),
    .addrE     (addrE),
    .wdataE    (wdataE),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .ctxM      (ctxM),
    .mdataM    (mdataM),
    .memerrM   (memerrM),
    .misalignM (misalignM),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        memen;
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] e_mdata;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata;
    logic        e_mis;
  } vec_t;

  vec_t tv[11];

  function automatic vec_t mk(
    input logic memen, input logic we, input logic [2:0] op,
    input logic [31:0] addr, input logic [31:0] wdata,
    input logic [31:0] rdata, input logic err,
    input logic [31:0] e_mdata, input logic [3:0] e_wstrb,
    input logic [31:0] e_wdata, input logic e_mis);
    vec_t v;
    v.memen = memen; v.we = we; v.op = op; v.addr = addr;
    v.wdata = wdata; v.rdata = rdata; v.err = err;
    v.e_mdata = e_mdata; v.e_wstrb = e_wstrb;
    v.e_wdata = e_wdata; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic chk(input string name,
                     input logic [CW-1:0] act,
                     input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_done(input vec_t v, input logic [CW-1:0] ctx);
    chk("m_valid", {351'b0, m_valid}, 1);
    chk("ctxM", ctxM, ctx);
    chk("mdataM", {320'b0, mdataM}, {320'b0, v.e_mdata});
    chk("memerrM", {351'b0, memerrM}, {351'b0, v.err});
    chk("misalignM", {351'b0, misalignM}, {351'b0, v.e_mis});
    chk("done_req_valid", {351'b0, bus.req_valid}, 0);
    chk("done_s_ready", {351'b0, s_ready}, 0);
  endtask

  // One instruction end to end with a scripted bus slave
  task automatic txn(input vec_t v, input logic [CW-1:0] ctx,
                     input int rstall, input int rdelay,
                     input int mhold);
    @(negedge clk);
    chk("s_ready_idle", {351'b0, s_ready}, 1);
    s_valid = 1'b1; ctxE = ctx; memenE = v.memen; memweE = v.we;
    memopE = v.op; addrE = v.addr; wdataE = v.wdata;
    @(posedge clk); #1;
    s_valid = 1'b0; ctxE = '0; memenE = 1'b0; memweE = 1'b0;
    addrE = '0; wdataE = '0;
    if (v.memen && !v.e_mis) begin
      for (int c = 0; c <= rstall; c++) begin
        chk("req_valid", {351'b0, bus.req_valid}, 1);
        chk("req_addr", {320'b0, bus.req_addr},
            {320'b0, v.addr[31:2], 2'b00});
        chk("req_we", {351'b0, bus.req_we}, {351'b0, v.we});
        chk("req_wstrb", {348'b0, bus.req_wstrb}, {348'b0, v.e_wstrb});
        if (v.we)
          chk("req_wdata", {320'b0, bus.req_wdata}, {320'b0, v.e_wdata});
        chk("m_valid_req", {351'b0, m_valid}, 0);
        bus.req_ready = (c == rstall);
        bus.rsp_valid = (c != rstall);
        bus.rsp_rdata = 32'hBAD0_BAD0;
        bus.rsp_err   = 1'b1;
        @(posedge clk); #1;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_err   = 1'b0;
      end
      for (int c = 0; c < rdelay; c++) begin
        chk("rsp_wait_req_valid", {351'b0, bus.req_valid}, 0);
        chk("rsp_wait_m_valid", {351'b0, m_valid}, 0);
        @(posedge clk); #1;
      end
      bus.rsp_valid = 1'b1;
      bus.rsp_rdata = v.rdata;
      bus.rsp_err   = v.err;
      @(posedge clk); #1;
      bus.rsp_valid = 1'b0;
      bus.rsp_rdata = '0;
      bus.rsp_err   = 1'b0;
    end else begin
      chk("no_req_valid", {351'b0, bus.req_valid}, 0);
      chk("no_req_wstrb", {348'b0, bus.req_wstrb}, 0);
    end
    chk_done(v, ctx);
    for (int c = 0; c < mhold; c++) begin
      @(posedge clk); #1;
      chk_done(v, ctx);
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    chk("m_valid_drop", {351'b0, m_valid}, 0);
    chk("s_ready_back", {351'b0, s_ready}, 1);
  endtask

  initial begin
    vec_t v;
    logic [CW-1:0] k;

    tv[0]  = mk(0, 0, MEMOP_W,  32'h0000_0055, 32'h0, 32'h0, 0,
                32'h0, 4'b0000, 32'h0, 0);
    tv[1]  = mk(1, 0, MEMOP_B,  32'h0000_1003, 32'h0, 32'h80AA_BBCC, 0,
                32'hFFFF_FF80, 4'b0000, 32'h0, 0);
    tv[2]  = mk(1, 0, MEMOP_BU, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 0,
                32'h0000_0080, 4'b0000, 32'h0, 0);
    tv[3]  = mk(1, 1, MEMOP_H,  32'h0000_2002, 32'h1234_ABCD, 32'h0, 0,
                32'h0, 4'b1100, 32'hABCD_0000, 0);
    tv[4]  = mk(1, 0, MEMOP_H,  32'h0000_3002, 32'h0, 32'h80AA_1234, 0,
                32'hFFFF_80AA, 4'b0000, 32'h0, 0);
    tv[5]  = mk(1, 0, MEMOP_HU, 32'h0000_3000, 32'h0, 32'h80AA_9234, 0,
                32'h0000_9234, 4'b0000, 32'h0, 0);
    tv[6]  = mk(1, 0, MEMOP_W,  32'h0000_4000, 32'h0, 32'hDEAD_BEEF, 0,
                32'hDEAD_BEEF, 4'b0000, 32'h0, 0);
    tv[7]  = mk(1, 1, MEMOP_B,  32'h0000_5001, 32'h0000_00A5, 32'h0, 0,
                32'h0, 4'b0010, 32'h0000_A500, 0);
    tv[8]  = mk(1, 1, MEMOP_W,  32'h0000_6000, 32'hCAFE_F00D, 32'h0, 0,
                32'h0, 4'b1111, 32'hCAFE_F00D, 0);
    tv[9]  = mk(1, 0, MEMOP_W,  32'h0000_6004, 32'h0, 32'h1234_5678, 1,
                32'h0, 4'b0000, 32'h0, 0);
    tv[10] = mk(1, 0, MEMOP_B,  32'h0000_7001, 32'h0, 32'h0000_7F00, 0,
                32'h0000_007F, 4'b0000, 32'h0, 0);

    rst = 1'b1; s_valid = 1'b0; ctxE = '0; memenE = 1'b0;
    memweE = 1'b0; memopE = '0; addrE = '0; wdataE = '0;
    m_ready = 1'b0;
    bus.req_ready = 1'b0; bus.rsp_valid = 1'b0;
    bus.rsp_rdata = '0; bus.rsp_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", {351'b0, s_ready}, 1);
    chk("rst_m_valid", {351'b0, m_valid}, 0);
    chk("rst_req_valid", {351'b0, bus.req_valid}, 0);
    chk("rst_ctxM", ctxM, '0);
    chk("rst_mdataM", {320'b0, mdataM}, 0);
    chk("rst_memerrM", {351'b0, memerrM}, 0);
    chk("rst_misalignM", {351'b0, misalignM}, 0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      k = {11{32'hC0DE_0000 + 32'(i)}};
      txn(tv[i], k, 0, 0, 0);
    end

    // Bus stalls, ignored early responses, W-stage backpressure
    k = {11{32'h5A11_0001}};
    txn(tv[3], k, 5, 3, 4);
    k = {11{32'h5A11_0002}};
    txn(tv[1], k, 2, 1, 2);

    // Reset while waiting for the response
    @(negedge clk);
    s_valid = 1'b1; ctxE = {11{32'hFEED_BEEF}}; memenE = 1'b1;
    memweE = 1'b1; memopE = MEMOP_W; addrE = 32'h0000_9000;
    wdataE = 32'h0BAD_F00D;
    @(posedge clk); #1;
    s_valid = 1'b0; memenE = 1'b0; memweE = 1'b0;
    bus.req_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_ready = 1'b0;
    chk("rsp_state_req_valid", {351'b0, bus.req_valid}, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_s_ready", {351'b0, s_ready}, 1);
    chk("mid_rst_m_valid", {351'b0, m_valid}, 0);
    chk("mid_rst_req_valid", {351'b0, bus.req_valid}, 0);
    chk("mid_rst_req_wstrb", {348'b0, bus.req_wstrb}, 0);
    chk("mid_rst_ctxM", ctxM, '0);
    chk("mid_rst_mdataM", {320'b0, mdataM}, 0);
    chk("mid_rst_memerrM", {351'b0, memerrM}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_m_valid", {351'b0, m_valid}, 0);

    // Misaligned word load
`ifdef LSU_MISALIGN_CHECK_EN
    v = mk(1, 0, MEMOP_W, 32'h0000_8001, 32'h0, 32'h1122_3344, 0,
           32'h0, 4'b0000, 32'h0, 1);
`else
    v = mk(1, 0, MEMOP_W, 32'h0000_8001, 32'h0, 32'h1122_3344, 0,
           32'h0011_2233, 4'b0000, 32'h0, 0);
`endif
    k = {11{32'hA11C_0001}};
    txn(v, k, 0, 0, 1);

    // A clean transaction after the misaligned one clears the flag
    k = {11{32'hA11C_0002}};
    txn(tv[6], k, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
